mpsoc_ahb3_mpram: RTL and testbench

Multi-port AHB3-Lite scratchpad memory: `PORTS` independent AHB slave ports share one single-ported word array through a round-robin arbiter with wait-state insertion. It is the parametrised successor of the per-node single-port AHB3 SPRAM hung off the `riscv_mpsoc3d` external AHB ports. One instance can serve several tiles, or one tile plus a DMA/debug master, with byte-lane writes and optional error signalling.

---
 rtl/mpsoc_ahb3_mpram.sv | 179 +++++++++++++++++
 tb/tb_mpsoc_ahb3_mpram.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_ahb3_mpram.sv
// Multi-port AHB3-Lite scratchpad: PORTS slave ports share one word array through a
// round-robin arbiter. Define MPSOC_AHB3_MPRAM_ERROR_EN to answer bad transfers with ERROR.
module mpsoc_ahb3_mpram #(
    parameter int PORTS     = 2,
    parameter int MEM_DEPTH = 256,
    parameter int PLEN      = 32,
    parameter int XLEN      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS-1:0]                 HSEL,
    input  logic [PORTS-1:0][PLEN-1:0]       HADDR,
    input  logic [PORTS-1:0][XLEN-1:0]       HWDATA,
    input  logic [PORTS-1:0]                 HWRITE,
    input  logic [PORTS-1:0][2:0]            HSIZE,
    input  logic [PORTS-1:0][2:0]            HBURST,
    input  logic [PORTS-1:0][3:0]            HPROT,
    input  logic [PORTS-1:0][1:0]            HTRANS,
    input  logic [PORTS-1:0]                 HMASTLOCK,
    input  logic [PORTS-1:0]                 HREADY,
    output logic [PORTS-1:0][XLEN-1:0]       HRDATA,
    output logic [PORTS-1:0]                 HREADYOUT,
    output logic [PORTS-1:0]                 HRESP
);
    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int PW   = (PORTS > 1) ? $clog2(PORTS) : 1;

`ifdef MPSOC_AHB3_MPRAM_ERROR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
`endif

    state_t                     state_q [PORTS];
    logic [PORTS-1:0]           hready_q;
    logic [PORTS-1:0]           hresp_q;
    logic [PORTS-1:0][XLEN-1:0] rdata_q;
    logic [PW-1:0]              ptr_q;
    logic [AW-1:0]              idx_q   [PORTS];
    logic [OFFW-1:0]            off_q   [PORTS];
    logic [2:0]                 size_q  [PORTS];
    logic [PORTS-1:0]           write_q;
    logic [PORTS-1:0]           lock_q;
    logic [XLEN-1:0]            mem_q   [MEM_DEPTH];

    logic [PORTS-1:0]           acc;
    logic [PORTS-1:0]           req;
    logic                       gnt_vld;
    logic [PW-1:0]              gnt_idx;
    logic [BW-1:0]              wstrb;
    logic                       unused_ok;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int i);
        return PW'((int'(base) + i) % PORTS);
    endfunction

    // Lanes of the naturally aligned container holding the addressed byte.
    function automatic logic [BW-1:0] strobes(input logic [OFFW-1:0] off, input logic [2:0] sz);
        int s;
        logic [BW-1:0] st;
        s = (int'(sz) > OFFW) ? OFFW : int'(sz);
        for (int b = 0; b < BW; b++)
            st[b] = ((b >> s) == (int'(off) >> s));
        return st;
    endfunction

`ifdef MPSOC_AHB3_MPRAM_ERROR_EN
    logic [PORTS-1:0] bad;

    function automatic logic bad_xfer(input logic [PLEN-1:0] a, input logic [2:0] sz);
        logic out_of_range;
        out_of_range = (a >> (OFFW + AW)) != '0;
        if (int'(sz) > OFFW)
            return 1'b1;
        return out_of_range || ((int'(a[OFFW-1:0]) & ((1 << sz) - 1)) != 0);
    endfunction

    always_comb begin
        for (int p = 0; p < PORTS; p++)
            bad[p] = bad_xfer(HADDR[p], HSIZE[p]);
    end
`endif

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            acc[p] = HSEL[p] & HREADY[p] & HTRANS[p][1];
            req[p] = (state_q[p] == S_WAIT);
        end
    end

    // Scan downward so the requester closest to the pointer is the last one assigned.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[rr_idx(ptr_q, i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_idx(ptr_q, i);
            end
        end
        wstrb = strobes(off_q[gnt_idx], size_q[gnt_idx]);
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (acc[p] && hready_q[p]) begin
                idx_q[p]   <= HADDR[p][OFFW +: AW];
                off_q[p]   <= HADDR[p][OFFW-1:0];
                size_q[p]  <= HSIZE[p];
                write_q[p] <= HWRITE[p];
                lock_q[p]  <= HMASTLOCK[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld && write_q[gnt_idx]) begin
            for (int b = 0; b < BW; b++)
                if (wstrb[b])
                    mem_q[idx_q[gnt_idx]][8*b +: 8] <= HWDATA[gnt_idx][8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            hready_q <= '1;
            hresp_q  <= '0;
            rdata_q  <= '0;
            for (int p = 0; p < PORTS; p++)
                state_q[p] <= S_IDLE;
        end else begin
            if (gnt_vld) begin
                ptr_q <= lock_q[gnt_idx] ? gnt_idx : rr_idx(gnt_idx, 1);
                if (!write_q[gnt_idx])
                    rdata_q[gnt_idx] <= mem_q[idx_q[gnt_idx]];
            end
            for (int p = 0; p < PORTS; p++) begin
                if (state_q[p] == S_WAIT) begin
                    if (gnt_vld && gnt_idx == PW'(p)) begin
                        state_q[p]  <= S_ACK;
                        hready_q[p] <= 1'b1;
                    end
                end
`ifdef MPSOC_AHB3_MPRAM_ERROR_EN
                else if (state_q[p] == S_ERR1) begin
                    state_q[p]  <= S_ERR2;
                    hready_q[p] <= 1'b1;
                end
`endif
                else if (acc[p]) begin
                    hready_q[p] <= 1'b0;
`ifdef MPSOC_AHB3_MPRAM_ERROR_EN
                    if (bad[p]) begin
                        state_q[p] <= S_ERR1;
                        hresp_q[p] <= 1'b1;
                    end else
`endif
                    begin
                        state_q[p] <= S_WAIT;
                        hresp_q[p] <= 1'b0;
                    end
                end else begin
                    state_q[p]  <= S_IDLE;
                    hready_q[p] <= 1'b1;
                    hresp_q[p]  <= 1'b0;
                end
            end
        end
    end

    assign HRDATA    = rdata_q;
    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    assign unused_ok = ^{HBURST, HPROT, HTRANS, HADDR};

endmodule

// File: tb/tb_mpsoc_ahb3_mpram.sv
// Directed bench for mpsoc_ahb3_mpram (two ports): beat tables per port, a word-array
// reference model and per-port expectation queues checked as each transfer completes.
module tb_mpsoc_ahb3_mpram;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       HSEL;
    logic [1:0][31:0] HADDR;
    logic [1:0][31:0] HWDATA;
    logic [1:0]       HWRITE;
    logic [1:0][2:0]  HSIZE;
    logic [1:0][2:0]  HBURST;
    logic [1:0][3:0]  HPROT;
    logic [1:0][1:0]  HTRANS;
    logic [1:0]       HMASTLOCK;
    logic [1:0]       HREADY;
    logic [1:0][31:0] HRDATA;
    logic [1:0]       HREADYOUT;
    logic [1:0]       HRESP;

    mpsoc_ahb3_mpram #(.PORTS(2), .MEM_DEPTH(256), .PLEN(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    always #5 clk = ~clk;
    assign HREADY = HREADYOUT;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        lock;
        int          waits;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic        chk;
        logic [31:0] data;
        int          waits;
        logic        resp;
    } exp_t;

    beat_t       bq0[$], bq1[$];
    exp_t        eq0[$], eq1[$];
    logic [31:0] mem_m [256];
    beat_t       tb_b;
    int          vec = 0;
    int          errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add(input int p, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic lock, input int waits);
        beat_t b;
        b.addr = addr; b.wr = wr; b.size = size; b.wdata = wdata; b.lock = lock; b.waits = waits;
        if (p == 0) bq0.push_back(b); else bq1.push_back(b);
    endtask

    // Reference: word array, byte lanes within the size-aligned container.
    task automatic model(input beat_t b, output exp_t e);
        int nb, base, widx;
        logic err;
        nb   = 1 << b.size;
        widx = int'((b.addr >> 2) % 256);
        err  = 1'b0;
`ifdef MPSOC_AHB3_MPRAM_ERROR_EN
        err = ((b.addr >> 2) >= 256) || (b.size > 3'd2) || ((b.addr % nb) != 0);
`endif
        e.addr  = b.addr;
        e.waits = b.waits;
        e.resp  = err;
        e.chk   = !b.wr && !err;
        e.data  = mem_m[widx];
        if (b.wr && !err) begin
            base = int'(b.addr[1:0]) & ~(nb - 1);
            for (int k = 0; k < 4; k++)
                if (k >= base && k < base + nb)
                    mem_m[widx][8*k +: 8] = b.wdata[8*k +: 8];
        end
    endtask

    task automatic drive(input int p, input beat_t b);
        HSEL[p] = 1'b1; HADDR[p] = b.addr; HWRITE[p] = b.wr; HSIZE[p] = b.size;
        HTRANS[p] = 2'b10; HMASTLOCK[p] = b.lock; HBURST[p] = 3'b000; HPROT[p] = 4'b0011;
    endtask

    task automatic idle(input int p);
        HSEL[p] = 1'b0; HTRANS[p] = 2'b00; HMASTLOCK[p] = 1'b0;
    endtask

    task automatic complete(input int p, input int w);
        exp_t e;
        if (p == 0) e = eq0.pop_front(); else e = eq1.pop_front();
        check($sformatf("p%0d@%08h waits", p, e.addr), 32'(w), 32'(e.waits));
        check($sformatf("p%0d@%08h hresp", p, e.addr), 32'(HRESP[p]), 32'(e.resp));
        if (e.chk)
            check($sformatf("p%0d@%08h hrdata", p, e.addr), HRDATA[p], e.data);
    endtask

    // Called #1 after a rising edge; issues queued beats whenever a port shows HREADYOUT=1.
    task automatic run();
        logic act0, act1, iss0, iss1;
        int w0, w1, steps;
        beat_t b0, b1;
        exp_t e;
        act0 = 1'b0; act1 = 1'b0; w0 = 0; w1 = 0; steps = 0;
        forever begin
            if (act0 && HREADYOUT[0]) begin complete(0, w0); act0 = 1'b0; end
            if (act1 && HREADYOUT[1]) begin complete(1, w1); act1 = 1'b0; end
            iss0 = 1'b0; iss1 = 1'b0;
            if (HREADYOUT[0] && bq0.size() > 0) begin
                b0 = bq0.pop_front(); drive(0, b0); model(b0, e); eq0.push_back(e); iss0 = 1'b1;
            end else idle(0);
            if (HREADYOUT[1] && bq1.size() > 0) begin
                b1 = bq1.pop_front(); drive(1, b1); model(b1, e); eq1.push_back(e); iss1 = 1'b1;
            end else idle(1);
            if (!act0 && !act1 && !iss0 && !iss1 && bq0.size() == 0 && bq1.size() == 0) break;
            steps++;
            if (steps > 100) begin
                check("run_timeout", 32'd1, 32'd0);
                bq0.delete(); bq1.delete(); eq0.delete(); eq1.delete();
                idle(0); idle(1);
                break;
            end
            @(posedge clk); #1;
            if (iss0) begin act0 = 1'b1; w0 = 0; HWDATA[0] = b0.wdata; end
            if (iss1) begin act1 = 1'b1; w1 = 0; HWDATA[1] = b1.wdata; end
            if (act0 && !HREADYOUT[0]) w0++;
            if (act1 && !HREADYOUT[1]) w1++;
        end
    endtask

    initial begin
        rst = 1'b1;
        HSEL = '0; HADDR = '0; HWDATA = '0; HWRITE = '0; HSIZE = '0;
        HBURST = '0; HPROT = '0; HTRANS = '0; HMASTLOCK = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset hreadyout", 32'(HREADYOUT), 32'h3);
        check("reset hresp", 32'(HRESP), 32'h0);
        check("reset hrdata0", HRDATA[0], 32'h0);
        check("reset hrdata1", HRDATA[1], 32'h0);

        // Single port, back-to-back write then read
        add(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 1);
        add(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        run();
        // Byte and halfword merges, then port 1 sees port 0's data
        add(0, 32'h11, 1'b1, 3'd0, 32'h0000A500, 1'b0, 1);
        add(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(0, 32'h12, 1'b1, 3'd1, 32'h12340000, 1'b0, 1);
        run();
        add(1, 32'h00, 1'b1, 3'd2, 32'h5A5A1234, 1'b0, 1);
        add(1, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        run();

        // Simultaneous requests, pointer at 0: port 0 first, port 1 waits one extra cycle
        add(0, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 1);
        add(1, 32'h30, 1'b0, 3'd2, 32'h0, 1'b0, 2);
        run();
        add(0, 32'h00, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(1, 32'h34, 1'b1, 3'd2, 32'h01020304, 1'b0, 2);
        run();
        // Both ports streaming four beats each
        add(0, 32'h40, 1'b1, 3'd2, 32'hAAAA0001, 1'b0, 1);
        add(0, 32'h40, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(0, 32'h44, 1'b1, 3'd2, 32'hAAAA0002, 1'b0, 1);
        add(0, 32'h34, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(1, 32'h30, 1'b0, 3'd2, 32'h0, 1'b0, 2);
        add(1, 32'h48, 1'b1, 3'd2, 32'hBBBB0003, 1'b0, 1);
        add(1, 32'h48, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(1, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        run();

        // Locked grant to port 1 keeps the pointer on port 1
        add(0, 32'h40, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(1, 32'h44, 1'b0, 3'd2, 32'h0, 1'b1, 2);
        run();
        add(0, 32'h48, 1'b0, 3'd2, 32'h0, 1'b0, 2);
        add(1, 32'h30, 1'b0, 3'd2, 32'h0, 1'b1, 1);
        run();
        add(0, 32'h00, 1'b0, 3'd2, 32'h0, 1'b0, 2);
        add(1, 32'h34, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        run();

        // Out-of-range and misaligned reads
        add(0, 32'h400, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(0, 32'h002, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        add(0, 32'h000, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        run();

        // Reset while a write is waiting drops the write
        add(1, 32'h50, 1'b1, 3'd2, 32'h11223344, 1'b0, 1);
        run();
        tb_b.addr = 32'h50; tb_b.wr = 1'b1; tb_b.size = 3'd2; tb_b.wdata = 32'hFFFFFFFF;
        tb_b.lock = 1'b0; tb_b.waits = 1;
        drive(1, tb_b);
        @(posedge clk); #1;
        idle(1);
        HWDATA[1] = 32'hFFFFFFFF;
        check("p1 wait before reset", 32'(HREADYOUT[1]), 32'h0);
        rst = 1'b1;
        #1;
        check("mid-wait reset hreadyout", 32'(HREADYOUT), 32'h3);
        check("mid-wait reset hresp", 32'(HRESP), 32'h0);
        check("mid-wait reset hrdata0", HRDATA[0], 32'h0);
        check("mid-wait reset hrdata1", HRDATA[1], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        add(1, 32'h50, 1'b0, 3'd2, 32'h0, 1'b0, 1);
        run();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation timeout");
    end
endmodule
